// File: rtl/ct_pkg.sv
// Shared types and constants for the loadable up/down counter.
package ct_pkg;

  localparam int CT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    CT_IDLE = 2'd0,
    CT_RUN  = 2'd1,
    CT_DONE = 2'd2
  } ct_state_e;

endpackage

// File: rtl/ct_load_counter_if.sv
// Parameter-input bus (ld/data plus count controls) and the counter's status outputs.
interface ct_load_counter_if #(
  parameter int DATA_WIDTH = ct_pkg::CT_DATA_WIDTH
);
  import ct_pkg::*;

  logic                  ld;
  logic [DATA_WIDTH-1:0] data;
  logic                  clr;
  logic                  en;
  logic                  up_dn;
  logic [DATA_WIDTH-1:0] count;
  logic                  tc;
  logic                  ovf;
  logic                  ld_ack;
  ct_state_e             state_o;

  modport master (
    output ld, data, clr, en, up_dn,
    input  count, tc, ovf, ld_ack, state_o
  );

  modport slave (
    input  ld, data, clr, en, up_dn,
    output count, tc, ovf, ld_ack, state_o
  );

endinterface

// File: rtl/ct_count_step.sv
// Combinational single-step arithmetic: next value, limit detection and wrap target.
module ct_count_step #(
  parameter int DATA_WIDTH = ct_pkg::CT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] count_i,
  input  logic                  up_dn_i,
  output logic [DATA_WIDTH-1:0] next_o,
  output logic                  at_limit_o,
  output logic [DATA_WIDTH-1:0] wrap_o
);

  localparam logic [DATA_WIDTH-1:0] MaxVal = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MinVal = '0;
  localparam logic [DATA_WIDTH-1:0] One    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_o     = up_dn_i ? (count_i + One) : (count_i - One);
    at_limit_o = up_dn_i ? (count_i == MaxVal) : (count_i == MinVal);
    wrap_o     = up_dn_i ? MinVal : MaxVal;
  end

endmodule

// File: rtl/ct_load_counter.sv
// Loadable up/down counter with terminal-count pulse, sticky overflow and optional saturation.
module ct_load_counter
  import ct_pkg::*;
#(
  parameter int DATA_WIDTH = CT_DATA_WIDTH,
  parameter bit SATURATE   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  ct_load_counter_if.slave   bus
);

  ct_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  tc_q, tc_d;
  logic                  ld_ack_q, ld_ack_d;

  logic [DATA_WIDTH-1:0] stepNext;
  logic [DATA_WIDTH-1:0] stepWrap;
  logic                  stepAtLimit;

  ct_count_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .count_i    (count_q),
    .up_dn_i    (bus.up_dn),
    .next_o     (stepNext),
    .at_limit_o (stepAtLimit),
    .wrap_o     (stepWrap)
  );

  // rst_n is active-high despite its name; it matches the surrounding codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= CT_IDLE;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tc_q     <= 1'b0;
      ld_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tc_q     <= tc_d;
      ld_ack_q <= ld_ack_d;
    end
  end

  // Priority clr > ld > en; counting only happens in RUN.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    tc_d     = 1'b0;
    ld_ack_d = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      if (state_q == CT_DONE) begin
        state_d = CT_RUN;
      end
    end else if (bus.ld) begin
      count_d  = bus.data;
      ld_ack_d = 1'b1;
      state_d  = CT_RUN;
    end else if ((state_q == CT_RUN) && bus.en) begin
      if (stepAtLimit) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SATURATE) begin
          state_d = CT_DONE;
        end else begin
          count_d = stepWrap;
        end
      end else begin
        count_d = stepNext;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.ld_ack  = ld_ack_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_ct_load_counter.sv
// Scoreboard bench for ct_load_counter: one wrap-mode and one saturate-mode instance.
module tb_ct_load_counter;
  import ct_pkg::*;

  typedef struct {
    logic [7:0] count;
    logic       tc;
    logic       ovf;
    logic       ack;
    logic [1:0] st;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;

  int nCompared;
  int nMismatched;

  exp_t qW[$];
  exp_t qS[$];

  ct_load_counter_if #(.DATA_WIDTH(8)) busW ();
  ct_load_counter_if #(.DATA_WIDTH(8)) busS ();

  ct_load_counter #(.DATA_WIDTH(8), .SATURATE(1'b0)) dutW (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busW.slave)
  );

  ct_load_counter #(.DATA_WIDTH(8), .SATURATE(1'b1)) dutS (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busS.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input exp_t e,
                             input logic [7:0] count, input logic tc, input logic ovf,
                             input logic ack, input logic [1:0] st);
    nCompared++;
    if ({count, tc, ovf, ack, st} !== {e.count, e.tc, e.ovf, e.ack, e.st}) begin
      nMismatched++;
      $display("[TB] FAIL %s: got count=%h tc=%b ovf=%b ld_ack=%b state=%0d, want count=%h tc=%b ovf=%b ld_ack=%b state=%0d",
               name, count, tc, ovf, ack, st, e.count, e.tc, e.ovf, e.ack, e.st);
    end
  endtask

  // Drives one cycle of inputs on the chosen instance and queues the expected post-edge outputs.
  task automatic applyStimulus(input bit sat, input string name,
                               input logic ld, input logic [7:0] data, input logic clr,
                               input logic en, input logic up,
                               input logic [7:0] eCount, input logic eTc, input logic eOvf,
                               input logic eAck, input ct_state_e eSt);
    exp_t e;
    @(negedge clk);
    if (sat) begin
      busS.ld = ld; busS.data = data; busS.clr = clr; busS.en = en; busS.up_dn = up;
    end else begin
      busW.ld = ld; busW.data = data; busW.clr = clr; busW.en = en; busW.up_dn = up;
    end
    e.count = eCount; e.tc = eTc; e.ovf = eOvf; e.ack = eAck; e.st = eSt; e.name = name;
    if (sat) qS.push_back(e);
    else     qW.push_back(e);
  endtask

  // Monitor: outputs are live every cycle, so each queued entry is checked just after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (qW.size() > 0) begin
        e = qW.pop_front();
        checkOutput({"W:", e.name}, e, busW.count, busW.tc, busW.ovf, busW.ld_ack, busW.state_o);
      end
      if (qS.size() > 0) begin
        e = qS.pop_front();
        checkOutput({"S:", e.name}, e, busS.count, busS.tc, busS.ovf, busS.ld_ack, busS.state_o);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t r;
    int waitCycles;
    nCompared   = 0;
    nMismatched = 0;
    busW.ld = 0; busW.data = '0; busW.clr = 0; busW.en = 0; busW.up_dn = 0;
    busS.ld = 0; busS.data = '0; busS.clr = 0; busS.en = 0; busS.up_dn = 0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    r.count = 8'h00; r.tc = 0; r.ovf = 0; r.ack = 0; r.st = CT_IDLE; r.name = "reset";
    checkOutput("reset_W", r, busW.count, busW.tc, busW.ovf, busW.ld_ack, busW.state_o);
    checkOutput("reset_S", r, busS.count, busS.tc, busS.ovf, busS.ld_ack, busS.state_o);
    @(negedge clk);
    rst_n = 1'b0;

    // Idle ignores en, then a load enters RUN
    applyStimulus(0, "idle_en0", 0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0, CT_IDLE);
    applyStimulus(0, "idle_en1", 0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0, CT_IDLE);
    applyStimulus(0, "ld_10",    1, 8'h10, 0, 0, 0, 8'h10, 0, 0, 1, CT_RUN);
    applyStimulus(0, "hold_10",  0, 8'h00, 0, 0, 0, 8'h10, 0, 0, 0, CT_RUN);

    // Wrap upward through MAX
    applyStimulus(0, "ld_FD",    1, 8'hFD, 0, 0, 1, 8'hFD, 0, 0, 1, CT_RUN);
    applyStimulus(0, "up_FE",    0, 8'h00, 0, 1, 1, 8'hFE, 0, 0, 0, CT_RUN);
    applyStimulus(0, "up_FF",    0, 8'h00, 0, 1, 1, 8'hFF, 0, 0, 0, CT_RUN);
    applyStimulus(0, "up_wrap",  0, 8'h00, 0, 1, 1, 8'h00, 1, 1, 0, CT_RUN);
    applyStimulus(0, "up_01",    0, 8'h00, 0, 1, 1, 8'h01, 0, 1, 0, CT_RUN);
    applyStimulus(0, "hold_ovf", 0, 8'h00, 0, 0, 0, 8'h01, 0, 1, 0, CT_RUN);

    // Clear drops ovf and counting resumes from zero
    applyStimulus(0, "clr",      0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, CT_RUN);
    applyStimulus(0, "after_c1", 0, 8'h00, 0, 1, 1, 8'h01, 0, 0, 0, CT_RUN);
    applyStimulus(0, "after_c2", 0, 8'h00, 0, 1, 1, 8'h02, 0, 0, 0, CT_RUN);

    // Priority collisions and back-to-back loads
    applyStimulus(0, "ld_en_33", 1, 8'h33, 0, 1, 1, 8'h33, 0, 0, 1, CT_RUN);
    applyStimulus(0, "clr_ld",   1, 8'h44, 1, 0, 0, 8'h00, 0, 0, 0, CT_RUN);
    applyStimulus(0, "b2b_55",   1, 8'h55, 0, 0, 0, 8'h55, 0, 0, 1, CT_RUN);
    applyStimulus(0, "b2b_66",   1, 8'h66, 0, 0, 0, 8'h66, 0, 0, 1, CT_RUN);

    // Underflow wrap, and loads of the limits raise no tc
    applyStimulus(0, "ld_00",    1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, CT_RUN);
    applyStimulus(0, "dn_wrap",  0, 8'h00, 0, 1, 0, 8'hFF, 1, 1, 0, CT_RUN);
    applyStimulus(0, "dn_FE",    0, 8'h00, 0, 1, 0, 8'hFE, 0, 1, 0, CT_RUN);
    applyStimulus(0, "ld_FF",    1, 8'hFF, 0, 0, 0, 8'hFF, 0, 1, 1, CT_RUN);
    applyStimulus(0, "hold_FF",  0, 8'h00, 0, 0, 0, 8'hFF, 0, 1, 0, CT_RUN);

    // Saturate instance: underflow into DONE, then recover by load
    applyStimulus(1, "ld_01",    1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 1, CT_RUN);
    applyStimulus(1, "dn_00",    0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, CT_RUN);
    applyStimulus(1, "dn_sat",   0, 8'h00, 0, 1, 0, 8'h00, 1, 1, 0, CT_DONE);
    applyStimulus(1, "done_dn",  0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 0, CT_DONE);
    applyStimulus(1, "done_up",  0, 8'h00, 0, 1, 1, 8'h00, 0, 1, 0, CT_DONE);
    applyStimulus(1, "ld_05",    1, 8'h05, 0, 0, 0, 8'h05, 0, 1, 1, CT_RUN);
    applyStimulus(1, "ld_FF",    1, 8'hFF, 0, 0, 1, 8'hFF, 0, 1, 1, CT_RUN);
    applyStimulus(1, "up_sat",   0, 8'h00, 0, 1, 1, 8'hFF, 1, 1, 0, CT_DONE);
    applyStimulus(1, "done_clr", 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, CT_RUN);
    applyStimulus(1, "up_01",    0, 8'h00, 0, 1, 1, 8'h01, 0, 0, 0, CT_RUN);
    applyStimulus(1, "hold_01",  0, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0, CT_RUN);

    // Count up to 0x80 with ovf set, then assert reset between edges
    applyStimulus(0, "ld_7E",    1, 8'h7E, 0, 0, 0, 8'h7E, 0, 1, 1, CT_RUN);
    applyStimulus(0, "up_7F",    0, 8'h00, 0, 1, 1, 8'h7F, 0, 1, 0, CT_RUN);
    applyStimulus(0, "up_80",    0, 8'h00, 0, 1, 1, 8'h80, 0, 1, 0, CT_RUN);
    applyStimulus(0, "hold_80",  0, 8'h00, 0, 0, 0, 8'h80, 0, 1, 0, CT_RUN);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    r.count = 8'h00; r.tc = 0; r.ovf = 0; r.ack = 0; r.st = CT_IDLE; r.name = "async_rst";
    checkOutput("async_rst", r, busW.count, busW.tc, busW.ovf, busW.ld_ack, busW.state_o);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, "post_rst", 0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0, CT_IDLE);
    applyStimulus(0, "post_ld",  1, 8'h21, 0, 0, 0, 8'h21, 0, 0, 1, CT_RUN);
    applyStimulus(0, "post_idl", 0, 8'h00, 0, 0, 0, 8'h21, 0, 0, 0, CT_RUN);

    waitCycles = 0;
    while ((qW.size() > 0 || qS.size() > 0) && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #5;
    if (qW.size() > 0 || qS.size() > 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain: got %0d entries pending, want 0", qW.size() + qS.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
